// File: rtl/immit_pkg.sv
// Shared constants, state encoding and helpers for the O.150 PRBS23 receive checker.
package immit_pkg;
  localparam int PRBS23_LEN   = 23;
  localparam int PRBS23_TAP_A = 22;
  localparam int PRBS23_TAP_B = 17;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} chk_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/prbs23_step8.sv
// Eight x^23+x^18+1 steps in one cycle, bit7 first; sel_rx feeds received bits instead of predictions.
module prbs23_step8
  import immit_pkg::*;
(
  input  logic [PRBS23_LEN-1:0] r_in,
  input  logic [7:0]            bits,
  input  logic                  sel_rx,
  output logic [PRBS23_LEN-1:0] r_out,
  output logic [7:0]            pred
);
  logic [PRBS23_LEN-1:0] r;
  logic                  p;

  always_comb begin
    r    = r_in;
    pred = '0;
    p    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      p       = r[PRBS23_TAP_A] ^ r[PRBS23_TAP_B];
      pred[i] = p;
      r       = {r[PRBS23_LEN-2:0], sel_rx ? bits[i] : p};
    end
    r_out = r;
  end
endmodule

// File: rtl/immit_data_checker.sv
// PRBS23 byte-stream checker: self-sync, verify, lock, error/byte counting and loss-of-lock window.
// Build option: CHECKER_INV_EN inverts data_in before all processing.
module immit_data_checker
  import immit_pkg::*;
#(
  parameter int N_VERIFY    = 4,
  parameter int WIN_BYTES   = 64,
  parameter int LOSS_THRESH = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in_en,
  input  logic [7:0]       data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_valid,
  output logic [3:0]       err_bits,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] byte_count,
  output logic             lock_lost
);
  localparam int VC_W = $clog2(N_VERIFY + 1);
  localparam int WB_W = $clog2(WIN_BYTES + 1);
  localparam int WE_W = $clog2(LOSS_THRESH + 9);

  chk_state_t            state;
  logic [PRBS23_LEN-1:0] r, r_nxt;
  logic [7:0]            din, pred_byte;
  logic [1:0]            feed_cnt;
  logic [VC_W-1:0]       ver_cnt;
  logic [WB_W-1:0]       win_bytes;
  logic [WE_W-1:0]       win_errs, win_sum;
  logic [3:0]            err_now;
  logic                  mism, lose, win_end;
  logic [CNT_W:0]        ec_sum, bc_sum;
  logic [CNT_W-1:0]      ec_nxt, bc_nxt;

`ifdef CHECKER_INV_EN
  assign din = ~data_in;
`else
  assign din = data_in;
`endif

  prbs23_step8 u_step (
    .r_in  (r),
    .bits  (din),
    .sel_rx(state == SEARCH),
    .r_out (r_nxt),
    .pred  (pred_byte)
  );

  assign err_now = popcount8(pred_byte ^ din);
  assign mism    = pred_byte != din;
  assign win_sum = win_errs + WE_W'(err_now);
  assign lose    = win_sum > WE_W'(LOSS_THRESH);
  assign win_end = win_bytes == WB_W'(WIN_BYTES - 1);

  // Saturating adds: the carry bit selects all-ones instead of wrapping.
  assign ec_sum = {1'b0, err_count} + (CNT_W+1)'(err_now);
  assign bc_sum = {1'b0, byte_count} + (CNT_W+1)'(1);
  assign ec_nxt = ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];
  assign bc_nxt = bc_sum[CNT_W] ? '1 : bc_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      r         <= '0;
      feed_cnt  <= '0;
      ver_cnt   <= '0;
      win_bytes <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_valid <= 1'b0;
      err_bits  <= '0;
      lock_lost <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      lock_lost <= 1'b0;
      if (data_in_en) begin
        r <= r_nxt;
        case (state)
          SEARCH: begin
            if (feed_cnt == 2'd2) begin
              feed_cnt <= '0;
              // An all-zero register is the LFSR's stuck state; keep filling.
              if (r_nxt != '0) begin
                ver_cnt <= '0;
                state   <= VERIFY;
              end
            end else begin
              feed_cnt <= feed_cnt + 2'd1;
            end
          end
          VERIFY: begin
            if (mism) begin
              state   <= SEARCH;
              ver_cnt <= '0;
            end else if (ver_cnt == VC_W'(N_VERIFY - 1)) begin
              state   <= LOCK;
              locked  <= 1'b1;
              ver_cnt <= '0;
            end else begin
              ver_cnt <= ver_cnt + VC_W'(1);
            end
          end
          LOCK: begin
            err_valid <= 1'b1;
            err_bits  <= err_now;
            if (lose) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              win_bytes <= '0;
              win_errs  <= '0;
            end else if (win_end) begin
              win_bytes <= '0;
              win_errs  <= '0;
            end else begin
              win_bytes <= win_bytes + WB_W'(1);
              win_errs  <= win_sum;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count  <= '0;
      byte_count <= '0;
    end else if (clear_cnt) begin
      err_count  <= '0;
      byte_count <= '0;
    end else if (data_in_en && state == LOCK) begin
      err_count  <= ec_nxt;
      byte_count <= bc_nxt;
    end
  end
endmodule

// File: tb/tb_immit_data_checker.sv
// Directed bench for immit_data_checker: table-driven lock/error run plus multi-cycle corner sequences.
module tb_immit_data_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic        data_in_en;
  logic [7:0]  data_in;
  logic        clear_cnt;
  logic        locked, err_valid, lock_lost;
  logic [3:0]  err_bits;
  logic [31:0] err_count, byte_count;

  immit_data_checker dut (
    .clk       (clk),
    .reset     (reset),
    .data_in_en(data_in_en),
    .data_in   (data_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_valid (err_valid),
    .err_bits  (err_bits),
    .err_count (err_count),
    .byte_count(byte_count),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        lk;
    logic        ev;
    logic [3:0]  eb;
    logic [31:0] ec;
    logic [31:0] bc;
  } vec_t;

  vec_t        tbl[64];
  int          checks = 0;
  int          errors = 0;
  logic [22:0] g;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Coder-imitator reference: all-ones seed gives 0x00,0x00,0x3E,...
  task automatic gen(output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      x    = g[17] ^ g[22];
      g    = {g[21:0], x};
      b[i] = x;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic clr);
    @(negedge clk);
`ifdef CHECKER_INV_EN
    data_in = ~d;
`else
    data_in = d;
`endif
    data_in_en = 1'b1;
    clear_cnt  = clr;
    @(posedge clk);
    #1;
    data_in_en = 1'b0;
    clear_cnt  = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_locked"}, 32'(locked), 0);
    chk({pfx, "_ev"}, 32'(err_valid), 0);
    chk({pfx, "_eb"}, 32'(err_bits), 0);
    chk({pfx, "_ec"}, err_count, 0);
    chk({pfx, "_bc"}, byte_count, 0);
    chk({pfx, "_lost"}, 32'(lock_lost), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    data_in_en = 1'b0;
    data_in    = 8'h00;
    clear_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic lock7(input string pfx);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      gen(b);
      drive(b, 1'b0);
      chk($sformatf("%s_lock%0d", pfx, i), 32'(locked), 32'(i == 6));
    end
  endtask

  task automatic run_table(input int gap);
    for (int i = 0; i < 64; i++) begin
      drive(tbl[i].d, 1'b0);
      chk($sformatf("g%0d_b%0d_locked", gap, i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("g%0d_b%0d_ev", gap, i), 32'(err_valid), 32'(tbl[i].ev));
      chk($sformatf("g%0d_b%0d_eb", gap, i), 32'(err_bits), 32'(tbl[i].eb));
      chk($sformatf("g%0d_b%0d_ec", gap, i), err_count, tbl[i].ec);
      chk($sformatf("g%0d_b%0d_bc", gap, i), byte_count, tbl[i].bc);
      repeat (gap) begin
        @(posedge clk);
        #1;
        chk($sformatf("g%0d_b%0d_idle_ev", gap, i), 32'(err_valid), 0);
        chk($sformatf("g%0d_b%0d_idle_lk", gap, i), 32'(locked), 32'(tbl[i].lk));
      end
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  e, e_last;
    logic [31:0] ec, bc;
    int          sum;
    logic        lost;

    // Lock completes on byte index 6; byte index 39 carries one flipped bit.
    g = '1;
    for (int i = 0; i < 64; i++) begin
      gen(b);
      tbl[i].d  = (i == 39) ? (b ^ 8'h01) : b;
      tbl[i].lk = (i >= 6);
      tbl[i].ev = (i >= 7);
      tbl[i].eb = (i == 39) ? 4'd1 : 4'd0;
      tbl[i].ec = (i >= 39) ? 32'd1 : 32'd0;
      tbl[i].bc = (i >= 7) ? 32'(i - 6) : 32'd0;
    end

    do_reset();
    run_table(0);
    do_reset();
    run_table(2);

    // 0xFF burst until window error sum exceeds 32, then relock on the live stream.
    do_reset();
    g = '1;
    lock7("ff");
    ec = 0; bc = 0; sum = 0; lost = 1'b0; e_last = 0;
    for (int i = 0; i < 3; i++) begin
      gen(b);
      drive(b, 1'b0);
      bc++;
    end
    for (int k = 0; k < 16 && !lost; k++) begin
      gen(b);
      e      = 4'($countones(~b));
      e_last = e;
      sum   += e;
      ec    += e;
      bc++;
      drive(8'hFF, 1'b0);
      chk($sformatf("ff%0d_eb", k), 32'(err_bits), 32'(e));
      if (sum > 32) begin
        chk("ff_lost_pulse", 32'(lock_lost), 1);
        chk("ff_lost_locked", 32'(locked), 0);
        lost = 1'b1;
      end else begin
        chk($sformatf("ff%0d_locked", k), 32'(locked), 1);
        chk($sformatf("ff%0d_nolost", k), 32'(lock_lost), 0);
      end
    end
    @(posedge clk);
    #1;
    chk("ff_pulse_end", 32'(lock_lost), 0);
    chk("ff_ec_hold", err_count, ec);
    chk("ff_bc_hold", byte_count, bc);
    lock7("ff_relock");
    chk("ff_eb_hold", 32'(err_bits), 32'(e_last));
    chk("ff_ec_after", err_count, ec);

    // Exactly 32 errors per window is tolerated; the window restarts after 64 bytes.
    do_reset();
    g = '1;
    lock7("win");
    for (int i = 0; i < 68; i++) begin
      gen(b);
      drive((i < 4 || i >= 64) ? ~b : b, 1'b0);
      chk($sformatf("win%0d_locked", i), 32'(locked), 1);
    end
    gen(b);
    drive(~b, 1'b0);
    chk("win_loss_locked", 32'(locked), 0);
    chk("win_loss_pulse", 32'(lock_lost), 1);
    chk("win_ec", err_count, 72);
    chk("win_bc", byte_count, 69);

    // All-zero stream never leaves SEARCH.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(8'h00, 1'b0);
      chk($sformatf("zero%0d_locked", i), 32'(locked), 0);
    end
    chk("zero_ev", 32'(err_valid), 0);
    chk("zero_ec", err_count, 0);
    chk("zero_bc", byte_count, 0);

    // clear_cnt wins over a simultaneous error byte.
    do_reset();
    g = '1;
    lock7("clr");
    gen(b);
    drive(b, 1'b0);
    chk("clr_bc1", byte_count, 1);
    gen(b);
    drive(b ^ 8'h03, 1'b1);
    chk("clr_ec", err_count, 0);
    chk("clr_bc", byte_count, 0);
    chk("clr_eb", 32'(err_bits), 2);
    chk("clr_ev", 32'(err_valid), 1);
    gen(b);
    drive(b ^ 8'h01, 1'b0);
    chk("clr_ec_next", err_count, 1);
    chk("clr_bc_next", byte_count, 1);

    // Asynchronous reset mid-LOCK, between edges.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero("async");
    @(negedge clk);
    reset = 1'b1;
    lock7("arelock");
    chk("arelock_ec", err_count, 0);
    chk("arelock_bc", byte_count, 0);
    gen(b);
    drive(b, 1'b0);
    chk("arelock_bc1", byte_count, 1);
    chk("arelock_ev", 32'(err_valid), 1);
    chk("arelock_eb", 32'(err_bits), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
